stall_mem_responder: RTL

- Multi-cycle data-memory responder for the pipelined processor's MEM stage; the memory-side end of the processor's Rd/Wr/Stall/Done interface.
- Accepts one word read or write per transaction, holds Stall high for a fixed latency, then pulses Done. On a read, Done comes with valid DataOut.
- After reset, clears its storage in an INIT sweep, so every simulation starts from deterministic all-zero memory.

---
 rtl/stall_mem_responder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/stall_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage (Rd/Wr/Stall/Done handshake).
// After reset an INIT sweep zeroes every word, then one word read or write is served per
// transaction: Stall is held for LAT cycles, then Done pulses for one cycle.
//
// Ports:
//   clk     - clock, all state updates on the rising edge
//   rst     - synchronous active-high reset
//   Addr    - byte address; word index = Addr[ADDR_W:1], upper bits ignored
//   DataIn  - write data
//   Rd, Wr  - read / write request (exactly one, with Addr[0]=0, is legal)
//   DataOut - read data, updated only on read completion (or cleared by reset)
//   Stall   - responder busy; request inputs must stay stable while high
//   Done    - one-cycle completion pulse
//   err     - one-cycle pulse the cycle after an illegal request
module stall_mem_responder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LAT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Stall,
  output logic        Done,
  output logic        err
);

  typedef enum logic [1:0] {StInit, StIdle, StBusy, StDone} state_e;

  localparam int unsigned Words = 2 ** ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_q, init_d;
  logic [3:0]          lat_q, lat_d;
  logic                err_q, err_d;
  logic [15:0]         data_out_q;
  logic                op_wr_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [15:0]         wdata_q;
  logic [15:0]         mem [Words];

  logic                req, illegal, legal, capture;
  logic [ADDR_W-1:0]   req_idx;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [15:0]         mem_wdata;
  logic                rd_load;
  logic [ADDR_W-1:0]   rd_idx;

  logic unused_addr;
  assign unused_addr = ^Addr[15:ADDR_W+1];

  assign req     = Rd | Wr;
  assign illegal = req & ((Rd & Wr) | Addr[0]);
  assign legal   = req & ~illegal;
  assign req_idx = Addr[ADDR_W:1];

  always_comb begin
    state_d   = state_q;
    init_d    = init_q;
    lat_d     = lat_q;
    err_d     = 1'b0;
    Stall     = 1'b0;
    Done      = 1'b0;
    capture   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = idx_q;
    mem_wdata = wdata_q;
    rd_load   = 1'b0;
    rd_idx    = idx_q;
    unique case (state_q)
      StInit: begin
        Stall     = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = init_q;
        mem_wdata = 16'h0000;
        init_d    = init_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (init_q == {ADDR_W{1'b1}}) begin
          state_d = StIdle;
        end
      end
      StIdle, StDone: begin
        Done = (state_q == StDone);
        if (legal) begin
          Stall   = 1'b1;
          capture = 1'b1;
          if (LAT == 1) begin
            // Single-cycle latency: commit straight from the request inputs.
            state_d   = StDone;
            mem_we    = Wr;
            mem_waddr = req_idx;
            mem_wdata = DataIn;
            rd_load   = Rd;
            rd_idx    = req_idx;
          end else begin
            state_d = StBusy;
            lat_d   = 4'(LAT - 1);
          end
        end else begin
          err_d   = illegal;
          state_d = StIdle;
        end
      end
      StBusy: begin
        Stall = 1'b1;
        if (lat_q == 4'd1) begin
          state_d = StDone;
          mem_we  = op_wr_q;
          rd_load = ~op_wr_q;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInit;
      init_q     <= '0;
      lat_q      <= '0;
      err_q      <= 1'b0;
      data_out_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
      if (rd_load) begin
        data_out_q <= mem[rd_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      op_wr_q <= Wr;
      idx_q   <= req_idx;
      wdata_q <= DataIn;
    end
  end

  // Gated by rst so a transaction cut short by reset never commits.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign DataOut = data_out_q;
  assign err     = err_q;

endmodule
